onchip_mem_arbiter: RTL

ONCHIP_MEM_ARBITER -- requirements
Module: onchip_mem_arbiter

---
 rtl/onchip_mem_arbiter.sv | 209 ++++++++++++++++++++
 1 files changed

// File: rtl/onchip_mem_arbiter.sv
// Two-master Avalon-MM arbiter in front of a single-cycle on-chip memory.
// Grants are combinational with a bounded hold; read data returns one cycle later.
module onchip_mem_arbiter #(
    parameter int ADDR_W   = 15,
    parameter int DATA_W   = 32,
    parameter int HOLD_MAX = 4
) (
    input  logic                clk,
    input  logic                reset_n,

    input  logic [ADDR_W-1:0]   m0_address,
    input  logic [DATA_W/8-1:0] m0_byteenable,
    input  logic                m0_read,
    input  logic                m0_write,
    input  logic [DATA_W-1:0]   m0_writedata,
    output logic                m0_waitrequest,
    output logic [DATA_W-1:0]   m0_readdata,
    output logic                m0_readdatavalid,

    input  logic [ADDR_W-1:0]   m1_address,
    input  logic [DATA_W/8-1:0] m1_byteenable,
    input  logic                m1_read,
    input  logic                m1_write,
    input  logic [DATA_W-1:0]   m1_writedata,
    output logic                m1_waitrequest,
    output logic [DATA_W-1:0]   m1_readdata,
    output logic                m1_readdatavalid,

    output logic [ADDR_W-1:0]   mem_address,
    output logic [DATA_W/8-1:0] mem_byteenable,
    output logic                mem_chipselect,
    output logic                mem_write,
    output logic [DATA_W-1:0]   mem_writedata,
    output logic                mem_clken,
    input  logic [DATA_W-1:0]   mem_readdata
);

    localparam int         BE_W     = DATA_W / 8;
    localparam logic [3:0] HOLD_LIM = 4'(HOLD_MAX);

    typedef enum logic [1:0] {
        OWN_NONE = 2'b00,
        OWN_M0   = 2'b01,
        OWN_M1   = 2'b10
    } owner_e;

    typedef enum logic [1:0] {
        TAG_NONE = 2'b00,
        TAG_M0   = 2'b01,
        TAG_M1   = 2'b10
    } tag_e;

    owner_e            owner_q, owner_d;
    logic [3:0]        hold_cnt_q, hold_cnt_d;
    logic              last_q, last_d;          // 1 = M1 was granted last
    tag_e              rd_tag_q, rd_tag_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [BE_W-1:0]   be_q, be_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;

    logic req0_s, req1_s;
    logic gnt0_s, gnt1_s;

    function automatic logic [3:0] sat_inc(input logic [3:0] cnt, input logic [3:0] lim);
        logic [3:0] res;
        if (cnt < lim) begin
            res = cnt + 4'd1;
        end else begin
            res = cnt;
        end
        return res;
    endfunction

    assign req0_s = m0_read | m0_write;
    assign req1_s = m1_read | m1_write;

    // Grant decision: single requester wins, contention resolved by hold count then fairness.
    always_comb begin
        gnt0_s = 1'b0;
        gnt1_s = 1'b0;
        if (!reset_n) begin
            gnt0_s = 1'b0;
            gnt1_s = 1'b0;
        end else if (req0_s && !req1_s) begin
            gnt0_s = 1'b1;
        end else if (req1_s && !req0_s) begin
            gnt1_s = 1'b1;
        end else if (req0_s && req1_s) begin
            case (owner_q)
                OWN_M0: begin
                    if (hold_cnt_q < HOLD_LIM) begin
                        gnt0_s = 1'b1;
                    end else begin
                        gnt1_s = 1'b1;
                    end
                end
                OWN_M1: begin
                    if (hold_cnt_q < HOLD_LIM) begin
                        gnt1_s = 1'b1;
                    end else begin
                        gnt0_s = 1'b1;
                    end
                end
                default: begin
                    if (last_q) begin
                        gnt0_s = 1'b1;
                    end else begin
                        gnt1_s = 1'b1;
                    end
                end
            endcase
        end else begin
            gnt0_s = 1'b0;
            gnt1_s = 1'b0;
        end
    end

    // Next-state for ownership, hold counter, read tag and held memory-side fields.
    always_comb begin
        owner_d    = owner_q;
        hold_cnt_d = hold_cnt_q;
        last_d     = last_q;
        rd_tag_d   = TAG_NONE;
        addr_d     = addr_q;
        be_d       = be_q;
        wdata_d    = wdata_q;
        if (gnt0_s) begin
            if (owner_q == OWN_M0) begin
                hold_cnt_d = sat_inc(hold_cnt_q, HOLD_LIM);
            end else begin
                owner_d    = OWN_M0;
                hold_cnt_d = 4'd1;
            end
            last_d   = 1'b0;
            rd_tag_d = (m0_read && !m0_write) ? TAG_M0 : TAG_NONE;
            addr_d   = m0_address;
            be_d     = m0_byteenable;
            wdata_d  = m0_writedata;
        end else if (gnt1_s) begin
            if (owner_q == OWN_M1) begin
                hold_cnt_d = sat_inc(hold_cnt_q, HOLD_LIM);
            end else begin
                owner_d    = OWN_M1;
                hold_cnt_d = 4'd1;
            end
            last_d   = 1'b1;
            rd_tag_d = (m1_read && !m1_write) ? TAG_M1 : TAG_NONE;
            addr_d   = m1_address;
            be_d     = m1_byteenable;
            wdata_d  = m1_writedata;
        end else begin
            owner_d    = OWN_NONE;
            hold_cnt_d = 4'd0;
        end
    end

    // State registers; last resets to M1 so that M0 wins the first contention.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            owner_q    <= OWN_NONE;
            hold_cnt_q <= 4'd0;
            last_q     <= 1'b1;
            rd_tag_q   <= TAG_NONE;
            addr_q     <= '0;
            be_q       <= '0;
            wdata_q    <= '0;
        end else begin
            owner_q    <= owner_d;
            hold_cnt_q <= hold_cnt_d;
            last_q     <= last_d;
            rd_tag_q   <= rd_tag_d;
            addr_q     <= addr_d;
            be_q       <= be_d;
            wdata_q    <= wdata_d;
        end
    end

    // Memory-side mux: granted port passes straight through, otherwise the last values persist.
    always_comb begin
        mem_address    = addr_q;
        mem_byteenable = be_q;
        mem_writedata  = wdata_q;
        mem_write      = 1'b0;
        if (gnt0_s) begin
            mem_address    = m0_address;
            mem_byteenable = m0_byteenable;
            mem_writedata  = m0_writedata;
            mem_write      = m0_write;
        end else if (gnt1_s) begin
            mem_address    = m1_address;
            mem_byteenable = m1_byteenable;
            mem_writedata  = m1_writedata;
            mem_write      = m1_write;
        end else begin
            mem_write      = 1'b0;
        end
    end

    assign mem_chipselect   = gnt0_s | gnt1_s;
    assign mem_clken        = reset_n;

    assign m0_waitrequest   = ~gnt0_s;
    assign m1_waitrequest   = ~gnt1_s;
    assign m0_readdatavalid = (rd_tag_q == TAG_M0);
    assign m1_readdatavalid = (rd_tag_q == TAG_M1);
    assign m0_readdata      = mem_readdata;
    assign m1_readdata      = mem_readdata;

endmodule
